hub75_blank_ctrl: RTL and testbench

//  Responder side of the BCM blanking handshake. Accepts a one-hot plane plus a go strobe

---
 rtl/hub75_blank_ctrl_pkg.sv | 21 ++
 rtl/hub75_blank_ctrl.sv | 99 +++++++++
 tb/tb_hub75_blank_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/hub75_blank_ctrl_pkg.sv
// Shared HUB75 definitions: blanking FSM state encoding and the one-hot
// plane decoder that the shifter uses as well.
package hub75_blank_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_GUARD = 2'd3
  } blank_state_e;

  // Index of the lowest set bit. A multi-hot input resolves to its lowest bit.
  // An all-zero input returns 0.
  function automatic logic [4:0] lsb_onehot2bin(input logic [31:0] v);
    lsb_onehot2bin = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) lsb_onehot2bin = 5'(i);
    end
  endfunction

endpackage

// File: rtl/hub75_blank_ctrl.sv
// BCM blanking responder. Holds the panel OE line low for a binary-weighted,
// brightness-dimmed on-time per plane, then reports ready to the sequencer.
module hub75_blank_ctrl
  import hub75_blank_ctrl_pkg::*;
#(
  parameter int N_PLANES = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_PLANES-1:0] blank_plane,
  input  logic                blank_go,
  output logic                blank_rdy,
  output logic                phy_blank,
  input  logic [7:0]          cfg_bcm_bit_len,
  input  logic [7:0]          cfg_brightness
);

  blank_state_e        state_q, state_d;
  logic [N_PLANES-1:0] plane_q, plane_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          bri_q, bri_d;
  logic [N_PLANES-1:0] unit_cnt_q, unit_cnt_d;
  logic [7:0]          pre_cnt_q, pre_cnt_d;
  logic                phy_blank_q, phy_blank_d;
  logic                blank_rdy_q, blank_rdy_d;
  logic [4:0]          idx;

  assign idx = lsb_onehot2bin(32'(plane_q));

  always_comb begin
    state_d     = state_q;
    plane_d     = plane_q;
    len_d       = len_q;
    bri_d       = bri_q;
    unit_cnt_d  = unit_cnt_q;
    pre_cnt_d   = pre_cnt_q;
    blank_rdy_d = blank_rdy_q;

    case (state_q)
      ST_IDLE: begin
        if (blank_go) begin
          plane_d     = blank_plane;
          len_d       = cfg_bcm_bit_len;
          bri_d       = cfg_brightness;
          blank_rdy_d = 1'b0;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        unit_cnt_d = {{(N_PLANES-1){1'b0}}, 1'b1} << idx;
        pre_cnt_d  = '0;
        state_d    = (plane_q == '0) ? ST_GUARD : ST_RUN;
      end
      ST_RUN: begin
        if (pre_cnt_q == len_q) begin
          pre_cnt_d = '0;
          if (unit_cnt_q != '0) unit_cnt_d = unit_cnt_q - 1'b1;
          if (unit_cnt_q == {{(N_PLANES-1){1'b0}}, 1'b1}) state_d = ST_GUARD;
        end else begin
          pre_cnt_d = pre_cnt_q + 8'd1;
        end
      end
      ST_GUARD: begin
        blank_rdy_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // pre_cnt never exceeds L, so brightness above L+1 saturates naturally.
    phy_blank_d = ~((state_q == ST_RUN) && (pre_cnt_q < bri_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      plane_q     <= '0;
      len_q       <= '0;
      bri_q       <= '0;
      unit_cnt_q  <= '0;
      pre_cnt_q   <= '0;
      phy_blank_q <= 1'b1;
      blank_rdy_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      plane_q     <= plane_d;
      len_q       <= len_d;
      bri_q       <= bri_d;
      unit_cnt_q  <= unit_cnt_d;
      pre_cnt_q   <= pre_cnt_d;
      phy_blank_q <= phy_blank_d;
      blank_rdy_q <= blank_rdy_d;
    end
  end

  assign phy_blank = phy_blank_q;
  assign blank_rdy = blank_rdy_q;

endmodule

// File: tb/tb_hub75_blank_ctrl.sv
// Self-checking bench for hub75_blank_ctrl: expected latency / on-time per
// transaction is queued at blank_go and checked when blank_rdy returns.
module tb_hub75_blank_ctrl;

  localparam int N_PLANES = 8;
  localparam int LIMIT    = 3000;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [N_PLANES-1:0] blank_plane = '0;
  logic                blank_go = 1'b0;
  logic                blank_rdy;
  logic                phy_blank;
  logic [7:0]          cfg_bcm_bit_len = '0;
  logic [7:0]          cfg_brightness = '0;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int lat;
    int lows;
    int plane;
  } exp_t;
  exp_t sb[$];

  hub75_blank_ctrl #(.N_PLANES(N_PLANES)) dut (
    .clk             (clk),
    .rst             (rst),
    .blank_plane     (blank_plane),
    .blank_go        (blank_go),
    .blank_rdy       (blank_rdy),
    .phy_blank       (phy_blank),
    .cfg_bcm_bit_len (cfg_bcm_bit_len),
    .cfg_brightness  (cfg_brightness)
  );

  always #5 clk = ~clk;

  function automatic int units_of(input int plane);
    units_of = 0;
    for (int i = N_PLANES - 1; i >= 0; i--) if (plane[i]) units_of = 1 << i;
  endfunction

  // Drives a go in the current cycle (cycle 0), runs until blank_rdy returns,
  // checks per-cycle OE pattern, total low clocks and ready latency.
  // mid_go > 0 pulses a second go with plane2 at that cycle.
  task automatic do_blank(input int plane, input int l, input int b,
                          input int mid_go, input int plane2);
    int u, c, lows, bad, unit;
    bit exp_low, done;
    exp_t e, got;
    u = units_of(plane);
    unit = l + 1;
    e.plane = plane;
    e.lat   = (u == 0) ? 3 : 3 + u * unit;
    e.lows  = u * ((b < unit) ? b : unit);
    sb.push_back(e);

    blank_plane     = N_PLANES'(plane);
    cfg_bcm_bit_len = 8'(l);
    cfg_brightness  = 8'(b);
    blank_go        = 1'b1;
    lows = 0; bad = 0; done = 1'b0;
    for (c = 1; c <= LIMIT; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        blank_go        = 1'b0;
        cfg_bcm_bit_len = 8'($urandom_range(0, 255));
        cfg_brightness  = 8'($urandom_range(0, 255));
        blank_plane     = N_PLANES'($urandom_range(0, 255));
      end
      if (mid_go > 0 && c == mid_go) begin
        blank_plane = N_PLANES'(plane2);
        blank_go    = 1'b1;
      end
      if (mid_go > 0 && c == mid_go + 1) blank_go = 1'b0;
      exp_low = (u > 0) && (c >= 3) && (c <= 2 + u * unit) && (((c - 3) % unit) < b);
      if (phy_blank === 1'b0) lows++;
      if (phy_blank !== !exp_low) begin
        if (bad == 0)
          $display("FAIL pattern plane=%02h cycle %0d: phy_blank=%b required %b",
                   plane, c, phy_blank, !exp_low);
        bad++;
      end
      if (blank_rdy === 1'b1) begin
        done = 1'b1;
        break;
      end
    end

    got = sb.pop_front();
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL timeout plane=%02h: blank_rdy not seen within %0d cycles", got.plane, LIMIT);
      blank_go = 1'b0;
      return;
    end
    vectors++;
    if (c !== got.lat) begin
      miscompares++;
      $display("FAIL latency plane=%02h: rdy at cycle %0d required %0d", got.plane, c, got.lat);
    end
    vectors++;
    if (lows !== got.lows) begin
      miscompares++;
      $display("FAIL low_count plane=%02h: %0d low clocks required %0d", got.plane, lows, got.lows);
    end
    if (bad !== 0) miscompares++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (phy_blank !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_phy_blank: got %b required 1", phy_blank);
    end
    vectors++;
    if (blank_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_blank_rdy: got %b required 1", blank_rdy);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_unit();
    do_blank(8'h01, 3, 4, 0, 0);
    do_blank(8'h04, 3, 2, 0, 0);
  endtask

  task automatic test_longest_plane();
    do_blank(8'h80, 3, 0, 0, 0);
    do_blank(8'h80, 3, 200, 0, 0);
  endtask

  task automatic test_ignored_go_and_zero();
    do_blank(8'h08, 2, 1, 6, 8'h80);
    do_blank(8'h00, 3, 4, 0, 0);
    do_blank(8'h0c, 1, 1, 0, 0);
  endtask

  task automatic test_async_reset();
    blank_plane = 8'h10; cfg_bcm_bit_len = 8'd3; cfg_brightness = 8'd4;
    blank_go = 1'b1;
    @(posedge clk); #1;
    blank_go = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    vectors++;
    if (phy_blank !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_run_unblank: phy_blank=%b required 0", phy_blank);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (phy_blank !== 1'b1 || blank_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset: phy_blank=%b blank_rdy=%b required 1 1", phy_blank, blank_rdy);
    end
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    do_blank(8'h02, 0, 1, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < N_PLANES; i++) do_blank(1 << i, 1, 2, 0, 0);
    for (int i = 0; i < 4; i++) do_blank(1 << i, 4, 3, 0, 0);
  endtask

  initial begin
    test_reset();
    test_single_unit();
    test_longest_plane();
    test_ignored_go_and_zero();
    test_async_reset();
    test_back_to_back();
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
